// File: rtl/fib_host_pkg.sv
// Shared constants and FSM state encoding for the Fibonacci core host.
package fib_host_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int CNT_WIDTH      = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/fib_timer.sv
// Job watchdog: down-counter loaded at job start, terminal count flagged by zero.
module fib_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/fib_host.sv
// Request/response wrapper around a Fibonacci core: holds the core in reset
// between jobs, captures its single write, and reports a timeout if none arrives.
//
// state   | meaning
// IDLE    | ready for a request, core held in reset
// RUN     | core released, waiting for its write or the timer to expire
// RESP    | response presented, core back in reset
module fib_host
  import fib_host_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_n,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [DATA_WIDTH-1:0] rsp_addr,
  output logic                  rsp_timeout,
  output logic                  fib_rst,
  output logic [DATA_WIDTH-1:0] fib_data_i,
  input  logic [DATA_WIDTH-1:0] fib_addr,
  input  logic [DATA_WIDTH-1:0] fib_data_o,
  input  logic                  fib_wen,
  output logic [CNT_WIDTH-1:0]  done_count,
  output logic [CNT_WIDTH-1:0]  timeout_count
);
  state_t state, state_nx;
  logic   accept, capture, expire, rsp_hs;
  logic   timer_zero;

  assign accept  = req_valid && req_ready;
  assign capture = (state == ST_RUN) && fib_wen;
  // A write arriving on the terminal-count cycle still counts as a result.
  assign expire  = (state == ST_RUN) && !fib_wen && timer_zero;
  assign rsp_hs  = rsp_valid && rsp_ready;

  fib_timer #(.WIDTH(DATA_WIDTH)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (DATA_WIDTH'(TIMEOUT)),
    .dec      ((state == ST_RUN) && !fib_wen),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    fib_rst   = 1'b1;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = ST_RUN;
      end
      ST_RUN: begin
        fib_rst = 1'b0;
        if (capture || expire) state_nx = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fib_data_i    <= '0;
      rsp_data      <= '0;
      rsp_addr      <= '0;
      rsp_timeout   <= 1'b0;
      done_count    <= '0;
      timeout_count <= '0;
    end else begin
      if (accept) fib_data_i <= req_n;
      if (capture) begin
        rsp_data    <= fib_data_o;
        rsp_addr    <= fib_addr;
        rsp_timeout <= 1'b0;
      end else if (expire) begin
        rsp_data    <= '0;
        rsp_addr    <= '0;
        rsp_timeout <= 1'b1;
      end
      if (rsp_hs) begin
        if (rsp_timeout) begin
          if (timeout_count != CNT_MAX) timeout_count <= timeout_count + CNT_WIDTH'(1);
        end else begin
          if (done_count != CNT_MAX) done_count <= done_count + CNT_WIDTH'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_fib_host.sv
// Bench for fib_host: behavioural Fibonacci core on one instance, directly
// driven stub cores on two short-timeout instances.
module tb_fib_host;
  localparam int DW = 32;
  localparam logic [DW-1:0] ADDR_BASE = 32'h0000_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // main instance with behavioural core
  logic          m_rst_n, m_req_valid, m_req_ready, m_rsp_valid, m_rsp_ready, m_rsp_timeout;
  logic          m_fib_rst, m_fib_wen;
  logic [DW-1:0] m_req_n, m_rsp_data, m_rsp_addr, m_fib_data_i, m_fib_addr, m_fib_data_o;
  logic [15:0]   m_done, m_tmo;

  fib_host #(.DATA_WIDTH(DW), .TIMEOUT(40)) dut (
    .clk(clk), .rst_n(m_rst_n), .req_valid(m_req_valid), .req_ready(m_req_ready),
    .req_n(m_req_n), .rsp_valid(m_rsp_valid), .rsp_ready(m_rsp_ready),
    .rsp_data(m_rsp_data), .rsp_addr(m_rsp_addr), .rsp_timeout(m_rsp_timeout),
    .fib_rst(m_fib_rst), .fib_data_i(m_fib_data_i), .fib_addr(m_fib_addr),
    .fib_data_o(m_fib_data_o), .fib_wen(m_fib_wen),
    .done_count(m_done), .timeout_count(m_tmo)
  );

  logic [DW-1:0] c_a, c_b, c_i;
  logic          c_done;
  always_ff @(posedge clk) begin
    if (m_fib_rst) begin
      c_a <= '0; c_b <= 32'd1; c_i <= '0; c_done <= 1'b0;
      m_fib_wen <= 1'b0; m_fib_addr <= '0; m_fib_data_o <= '0;
    end else begin
      m_fib_wen <= 1'b0;
      if (!c_done) begin
        if (c_i == m_fib_data_i) begin
          m_fib_wen <= 1'b1; m_fib_data_o <= c_a; m_fib_addr <= ADDR_BASE + c_i; c_done <= 1'b1;
        end else begin
          c_a <= c_b; c_b <= c_a + c_b; c_i <= c_i + 32'd1;
        end
      end
    end
  end

  // stub instances share one tb-driven core write port
  logic          st_rst_n, sb_wen;
  logic [DW-1:0] sb_addr, sb_data;
  logic          s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready, s_rsp_timeout, s_fib_rst;
  logic [DW-1:0] s_req_n, s_rsp_data, s_rsp_addr, s_fib_data_i;
  logic [15:0]   s_done, s_tmo;
  logic          t_req_valid, t_req_ready, t_rsp_valid, t_rsp_ready, t_rsp_timeout, t_fib_rst;
  logic [DW-1:0] t_req_n, t_rsp_data, t_rsp_addr, t_fib_data_i;
  logic [15:0]   t_done, t_tmo;

  fib_host #(.DATA_WIDTH(DW), .TIMEOUT(5)) dut_s (
    .clk(clk), .rst_n(st_rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_n(s_req_n), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_data(s_rsp_data), .rsp_addr(s_rsp_addr), .rsp_timeout(s_rsp_timeout),
    .fib_rst(s_fib_rst), .fib_data_i(s_fib_data_i), .fib_addr(sb_addr),
    .fib_data_o(sb_data), .fib_wen(sb_wen), .done_count(s_done), .timeout_count(s_tmo)
  );

  fib_host #(.DATA_WIDTH(DW), .TIMEOUT(3)) dut_t (
    .clk(clk), .rst_n(st_rst_n), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_n(t_req_n), .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready),
    .rsp_data(t_rsp_data), .rsp_addr(t_rsp_addr), .rsp_timeout(t_rsp_timeout),
    .fib_rst(t_fib_rst), .fib_data_i(t_fib_data_i), .fib_addr(sb_addr),
    .fib_data_o(sb_data), .fib_wen(sb_wen), .done_count(t_done), .timeout_count(t_tmo)
  );

  task automatic m_job(input logic [DW-1:0] n, output logic [DW-1:0] d,
                       output logic [DW-1:0] a, output logic to);
    int guard;
    @(negedge clk);
    m_req_n = n; m_req_valid = 1'b1;
    guard = 0;
    while (!m_req_ready && guard < 50) begin @(negedge clk); guard++; end
    check("m_req_ready_seen", m_req_ready, 1);
    @(negedge clk);
    m_req_valid = 1'b0;
    guard = 0;
    while (!m_rsp_valid && guard < 200) begin @(negedge clk); guard++; end
    check("m_rsp_valid_seen", m_rsp_valid, 1);
    d = m_rsp_data; a = m_rsp_addr; to = m_rsp_timeout;
    m_rsp_ready = 1'b1;
    @(negedge clk);
    m_rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [DW-1:0] n;
    logic [DW-1:0] exp_d;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d, a;
    logic          to, ok, seen;
    int            runs, guard;

    vecs[0] = '{32'd0, 32'd0};  vecs[1] = '{32'd1, 32'd1};
    vecs[2] = '{32'd2, 32'd1};  vecs[3] = '{32'd3, 32'd2};
    vecs[4] = '{32'd4, 32'd3};  vecs[5] = '{32'd5, 32'd5};
    vecs[6] = '{32'd6, 32'd8};  vecs[7] = '{32'd10, 32'd55};

    m_rst_n = 1'b0; st_rst_n = 1'b0;
    m_req_valid = 1'b0; m_req_n = '0; m_rsp_ready = 1'b0;
    s_req_valid = 1'b0; s_req_n = '0; s_rsp_ready = 1'b0;
    t_req_valid = 1'b0; t_req_n = '0; t_rsp_ready = 1'b0;
    sb_wen = 1'b0; sb_addr = '0; sb_data = '0;
    repeat (2) @(negedge clk);

    check("rst_fib_rst", m_fib_rst, 1);
    check("rst_fib_data_i", m_fib_data_i, 0);
    check("rst_rsp_valid", m_rsp_valid, 0);
    check("rst_rsp_data", m_rsp_data, 0);
    check("rst_rsp_addr", m_rsp_addr, 0);
    check("rst_rsp_timeout", m_rsp_timeout, 0);
    check("rst_done", m_done, 0);
    check("rst_tmo", m_tmo, 0);
    check("rst_req_ready", m_req_ready, 1);
    m_rst_n = 1'b1; st_rst_n = 1'b1;

    // reset mid-RUN abandons the job
    @(negedge clk);
    m_req_n = 32'd6; m_req_valid = 1'b1;
    @(negedge clk);
    m_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun_in_run", m_fib_rst, 0);
    m_rst_n = 1'b0;
    #1;
    check("midrun_fib_rst", m_fib_rst, 1);
    check("midrun_req_ready", m_req_ready, 1);
    check("midrun_fib_data_i", m_fib_data_i, 0);
    @(negedge clk);
    m_rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (m_rsp_valid) seen = 1'b1; end
    check("midrun_no_rsp", seen, 0);
    check("midrun_done", m_done, 0);
    check("midrun_tmo", m_tmo, 0);
    m_job(32'd5, d, a, to);
    check("after_rst_n5_data", d, 5);
    check("after_rst_n5_to", to, 0);
    check("after_rst_done", m_done, 1);

    // fresh reset, then the vector table
    @(negedge clk); m_rst_n = 1'b0;
    @(negedge clk); m_rst_n = 1'b1;
    check("rerst_done", m_done, 0);
    for (int i = 0; i < 8; i++) begin
      m_job(vecs[i].n, d, a, to);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_d);
      check($sformatf("vec%0d_addr", i), a, ADDR_BASE + vecs[i].n);
      check($sformatf("vec%0d_to", i), to, 0);
      if (i == 6) check("done_after_0to6", m_done, 7);
    end
    check("done_after_10", m_done, 8);

    // response held 20 cycles with rsp_ready low
    @(negedge clk);
    m_req_n = 32'd4; m_req_valid = 1'b1;
    @(negedge clk);
    m_req_valid = 1'b0;
    ok = 1'b1; guard = 0;
    while (!m_rsp_valid && guard < 100) begin
      if (m_fib_data_i !== 32'd4 || m_req_ready !== 1'b0) ok = 1'b0;
      @(negedge clk); guard++;
    end
    check("hold_run_stable", ok, 1);
    check("hold_rsp_seen", m_rsp_valid, 1);
    ok = 1'b1;
    repeat (20) begin
      if (m_rsp_data !== 32'd3 || m_rsp_addr !== ADDR_BASE + 32'd4 ||
          m_req_ready !== 1'b0 || m_fib_rst !== 1'b1 || m_rsp_valid !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    check("hold_resp_stable", ok, 1);
    check("hold_done_before_hs", m_done, 8);
    m_rsp_ready = 1'b1;
    @(negedge clk);
    m_rsp_ready = 1'b0;
    check("hold_done_after_hs", m_done, 9);

    // fib_wen while idle is ignored
    sb_wen = 1'b1; sb_data = 32'hAB; sb_addr = 32'hCD;
    repeat (2) @(negedge clk);
    sb_wen = 1'b0;
    check("idle_wen_no_rsp", s_rsp_valid, 0);
    check("idle_wen_ready", s_req_ready, 1);

    // minimum latency, only the first write captured
    s_req_n = 32'd3; s_req_valid = 1'b1;
    @(negedge clk);
    s_req_valid = 1'b0;
    check("minlat_run", s_fib_rst, 0);
    sb_wen = 1'b1; sb_data = 32'h11; sb_addr = 32'h21;
    @(negedge clk);
    check("minlat_rsp_valid", s_rsp_valid, 1);
    sb_data = 32'h22; sb_addr = 32'h32;
    @(negedge clk);
    sb_wen = 1'b0;
    check("first_wen_data", s_rsp_data, 32'h11);
    check("first_wen_addr", s_rsp_addr, 32'h21);
    check("first_wen_to", s_rsp_timeout, 0);

    // back-to-back: request held during the handshake
    s_rsp_ready = 1'b1; s_req_valid = 1'b1; s_req_n = 32'd7;
    #1;
    check("hs_no_req_ready", s_req_ready, 0);
    @(negedge clk);
    s_rsp_ready = 1'b0;
    check("b2b_idle_fib_rst", s_fib_rst, 1);
    check("b2b_idle_ready", s_req_ready, 1);
    check("b2b_done", s_done, 1);
    @(negedge clk);
    s_req_valid = 1'b0;

    // timeout with TIMEOUT=5 and a silent core
    runs = 0; guard = 0; ok = 1'b1;
    while (!s_rsp_valid && guard < 100) begin
      if (!s_fib_rst) runs++;
      if (s_fib_data_i !== 32'd7) ok = 1'b0;
      @(negedge clk); guard++;
    end
    check("tmo_run_cycles", runs, 6);
    check("tmo_arg_stable", ok, 1);
    check("tmo_flag", s_rsp_timeout, 1);
    check("tmo_data", s_rsp_data, 0);
    check("tmo_addr", s_rsp_addr, 0);
    s_rsp_ready = 1'b1;
    @(negedge clk);
    s_rsp_ready = 1'b0;
    check("tmo_count", s_tmo, 1);
    check("tmo_done_unchanged", s_done, 1);

    // TIMEOUT=3: write lands on the terminal-count cycle
    t_req_n = 32'd9; t_req_valid = 1'b1;
    @(negedge clk);
    t_req_valid = 1'b0;
    runs = 1;
    while (runs < 4) begin @(negedge clk); runs++; end
    check("tie_still_run", t_fib_rst, 0);
    sb_wen = 1'b1; sb_data = 32'h99; sb_addr = 32'h77;
    @(negedge clk);
    sb_wen = 1'b0;
    check("tie_rsp_valid", t_rsp_valid, 1);
    check("tie_to", t_rsp_timeout, 0);
    check("tie_data", t_rsp_data, 32'h99);
    check("tie_addr", t_rsp_addr, 32'h77);
    t_rsp_ready = 1'b1;
    @(negedge clk);
    t_rsp_ready = 1'b0;
    check("tie_done", t_done, 1);
    check("tie_tmo", t_tmo, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
